// File: rtl/xor_sweep_checker_if.sv
// Bundles the sweep checker's control, stimulus and result signals.
// Purely combinational wiring; no latency.
// No backpressure: start is a level or pulse; results are held until restart.
interface xor_sweep_checker_if #(
    parameter int N_IN = 2
);
    logic                 start;
    logic [N_IN-1:0]      vec;
    logic                 s_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   truth_table;
    logic [N_IN:0]        err_count;
    logic                 fail_valid;
    logic [N_IN-1:0]      fail_index;

    // Checker side: drives stimulus and results, reads start and gate output.
    modport master (
        input  start,
        input  s_in,
        output vec,
        output busy,
        output done,
        output pass,
        output truth_table,
        output err_count,
        output fail_valid,
        output fail_index
    );

    // Environment side: kicks off sweeps and supplies the gate output.
    modport slave (
        output start,
        output s_in,
        input  vec,
        input  busy,
        input  done,
        input  pass,
        input  truth_table,
        input  err_count,
        input  fail_valid,
        input  fail_index
    );
endinterface

// File: rtl/xor_sweep_checker.sv
// Sweeps every input vector of a small gate, samples its output, checks it against EXPECTED.
// Latency: done rises 2^N_IN*(SETTLE+1) edges after the edge that samples start.
// No backpressure: start is only honoured in IDLE/DONE and ignored mid-sweep.
module xor_sweep_checker #(
    parameter int                  N_IN     = 2,
    parameter int                  SETTLE   = 1,
    parameter logic [2**N_IN-1:0]  EXPECTED = 4'b0110
) (
    input  logic                  clk,
    input  logic                  reset,
    xor_sweep_checker_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

    localparam logic [3:0]      CNT_INIT = 4'(SETTLE - 1);
    localparam logic [3:0]      CNT_ONE  = 4'd1;
    localparam logic [N_IN-1:0] VEC_ONE  = 1;
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN:0]   ERR_ONE  = 1;

    state_t               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2**N_IN-1:0]   tbl_q, tbl_d;
    logic [N_IN:0]        err_q, err_d;
    logic                 fv_q, fv_d;
    logic [N_IN-1:0]      fi_q, fi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 mism;

    // Next-state and result update; s_in only influences state in SAMPLE.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fi_d    = fi_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        mism    = (bus.s_in != EXPECTED[vec_q]);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_HOLD;
                    vec_d   = '0;
                    cnt_d   = CNT_INIT;
                    tbl_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fi_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                tbl_d[vec_q] = bus.s_in;
                if (mism) begin
                    err_d = err_q + ERR_ONE;
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fi_d = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    // Last vector is held; pass includes this final sample.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0) && !mism;
                end else begin
                    state_d = S_HOLD;
                    vec_d   = vec_q + VEC_ONE;
                    cnt_d   = CNT_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fi_q    <= fi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec         = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.truth_table = tbl_q;
    assign bus.err_count   = err_q;
    assign bus.fail_valid  = fv_q;
    assign bus.fail_index  = fi_q;
endmodule
